// File: rtl/fft_frame_serializer_if.sv
// Frame-in / sample-out bus of the FFT frame serializer.
// The slave modport is the serializer side; the master modport is the producer/sink side.
interface fft_frame_serializer_if #(
  parameter int WORD_SIZE = 16,
  parameter int N_POINTS  = 16
);
  logic                          load;
  logic [N_POINTS*WORD_SIZE-1:0] in_re;
  logic [N_POINTS*WORD_SIZE-1:0] in_im;
  logic [WORD_SIZE-1:0]          out_re;
  logic [WORD_SIZE-1:0]          out_im;
  logic [3:0]                    out_idx;
  logic                          out_valid;
  logic                          out_last;
  logic                          out_ready;
  logic                          busy;
  logic                          overrun;
  logic                          clr_ovr;

  modport slave (
    input  load, in_re, in_im, out_ready, clr_ovr,
    output out_re, out_im, out_idx, out_valid, out_last, busy, overrun
  );

  modport master (
    output load, in_re, in_im, out_ready, clr_ovr,
    input  out_re, out_im, out_idx, out_valid, out_last, busy, overrun
  );
endinterface

// File: rtl/fft_frame_serializer.sv
// Captures a 16-point complex FFT frame on load and streams it one sample per cycle.
// Optional macro FFT_SER_BITREV_EN streams in bit-reversed buffer order.
module fft_frame_serializer #(
  parameter int WORD_SIZE = 16,
  parameter int N_POINTS  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  fft_frame_serializer_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;

  state_t                             state, state_nxt;
  logic [3:0]                         step, step_nxt, rd_idx;
  logic [N_POINTS-1:0][WORD_SIZE-1:0] buf_re, buf_im;
  logic [WORD_SIZE-1:0]               rd_re, rd_im, re_q, im_q;
  logic [3:0]                         idx_q;
  logic                               capture, drop, hs, ovr_q;

  function automatic logic [3:0] sel(input logic [3:0] s);
`ifdef FFT_SER_BITREV_EN
    return {s[0], s[1], s[2], s[3]};
`else
    return s;
`endif
  endfunction

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    capture   = 1'b0;
    drop      = 1'b0;
    hs        = (state == STREAM) && bus.out_ready;
    case (state)
      IDLE: if (bus.load) begin
        capture   = 1'b1;
        step_nxt  = 4'd0;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (hs) begin
          if (step == 4'd15) begin
            step_nxt = 4'd0;
            // A load on the final handshake chains the next frame with no bubble.
            if (bus.load) capture = 1'b1;
            else          state_nxt = IDLE;
          end else begin
            step_nxt = step + 4'd1;
          end
        end
        drop = bus.load && !(hs && step == 4'd15);
      end
      default: state_nxt = IDLE;
    endcase
    // On capture the buffer is not yet written, so read the sample straight from the input.
    rd_idx = sel(step_nxt);
    rd_re  = capture ? bus.in_re[rd_idx*WORD_SIZE +: WORD_SIZE] : buf_re[rd_idx];
    rd_im  = capture ? bus.in_im[rd_idx*WORD_SIZE +: WORD_SIZE] : buf_im[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      step   <= 4'd0;
      buf_re <= '0;
      buf_im <= '0;
      re_q   <= '0;
      im_q   <= '0;
      idx_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      if (capture) begin
        buf_re <= bus.in_re;
        buf_im <= bus.in_im;
      end
      if (state_nxt == STREAM) begin
        re_q  <= rd_re;
        im_q  <= rd_im;
        idx_q <= rd_idx;
      end else begin
        re_q  <= '0;
        im_q  <= '0;
        idx_q <= '0;
      end
      if (drop)             ovr_q <= 1'b1;
      else if (bus.clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign bus.out_re    = re_q;
  assign bus.out_im    = im_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = (state == STREAM);
  assign bus.out_last  = (state == STREAM) && (step == 4'd15);
  assign bus.busy      = (state == STREAM);
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed bench for fft_frame_serializer: reset, single frame, backpressure,
// back-to-back frames, overrun and mid-frame reset.
module tb_fft_frame_serializer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   ord [16];

  always #5 clk = ~clk;

  fft_frame_serializer_if #(.WORD_SIZE(W)) bus ();

  fft_frame_serializer #(.WORD_SIZE(W), .N_POINTS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // kind 0: re=k+1, im=-(k+1); kind 1: re=0x100+k, im=0x200+k
  task automatic set_frame(input int kind);
    for (int k = 0; k < 16; k++) begin
      if (kind == 0) begin
        bus.in_re[k*W +: W] = 16'(k + 1);
        bus.in_im[k*W +: W] = 16'(-(k + 1));
      end else begin
        bus.in_re[k*W +: W] = 16'(16'h100 + k);
        bus.in_im[k*W +: W] = 16'(16'h200 + k);
      end
    end
  endtask

  function automatic logic [15:0] exp_re(input int kind, input int k);
    return (kind == 0) ? 16'(k + 1) : 16'(16'h100 + k);
  endfunction

  function automatic logic [15:0] exp_im(input int kind, input int k);
    return (kind == 0) ? 16'(-(k + 1)) : 16'(16'h200 + k);
  endfunction

  // Checks the sample currently on the outputs as the n-th of a frame.
  task automatic chk_sample(input string tag, input int kind, input int n);
    int k;
    k = ord[n];
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_re !== exp_re(kind, k) || bus.out_im !== exp_im(kind, k) ||
        bus.out_idx !== 4'(k) || bus.out_last !== (n == 15) || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s n=%0d: got v=%b re=%h im=%h idx=%0d last=%b busy=%b, want v=1 re=%h im=%h idx=%0d last=%b busy=1",
               tag, n, bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.busy,
               exp_re(kind, k), exp_im(kind, k), k, (n == 15));
    end
  endtask

  task automatic chk_idle(input string tag, input logic ovr);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.out_re !== 16'h0 ||
        bus.out_im !== 16'h0 || bus.out_idx !== 4'h0 || bus.overrun !== ovr) begin
      errors++;
      $display("FAIL %s: got v=%b last=%b busy=%b re=%h im=%h idx=%0d ovr=%b, want all 0 ovr=%b",
               tag, bus.out_valid, bus.out_last, bus.busy, bus.out_re, bus.out_im, bus.out_idx, bus.overrun, ovr);
    end
  endtask

  task automatic chk_ovr(input string tag, input logic want);
    checks++;
    if (bus.overrun !== want) begin
      errors++;
      $display("FAIL %s: overrun=%b want %b", tag, bus.overrun, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    chk_idle("reset_outputs", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle("idle_after_reset", 1'b0);
    end
  endtask

  task automatic test_single_frame;
    set_frame(0);
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      bus.load = 1'b0;
      chk_sample("single", 0, n);
    end
    @(negedge clk);
    chk_idle("single_end", 1'b0);
  endtask

  task automatic test_backpressure;
    int n, cyc;
    logic prev_stall;
    logic [15:0] pre, pim;
    logic [3:0] pidx;
    logic plast;
    n = 0; cyc = 0; prev_stall = 1'b0;
    pre = '0; pim = '0; pidx = '0; plast = 1'b0;
    set_frame(0);
    bus.out_ready = 1'b0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    while (n < 16 && cyc < 100) begin
      if (prev_stall) begin
        checks++;
        if (bus.out_re !== pre || bus.out_im !== pim || bus.out_idx !== pidx || bus.out_last !== plast) begin
          errors++;
          $display("FAIL bp_hold: got re=%h im=%h idx=%0d last=%b, want re=%h im=%h idx=%0d last=%b",
                   bus.out_re, bus.out_im, bus.out_idx, bus.out_last, pre, pim, pidx, plast);
        end
      end
      chk_sample("bp", 0, n);
      bus.out_ready = (cyc % 3 == 0);
      prev_stall = !bus.out_ready;
      pre = bus.out_re; pim = bus.out_im; pidx = bus.out_idx; plast = bus.out_last;
      if (bus.out_ready) n++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL bp_timeout: accepted %0d want 16", n);
    end
    chk_idle("bp_end", 1'b0);
    bus.out_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    set_frame(0);
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      bus.load = 1'b0;
      chk_sample("b2b_f1", 0, n);
      if (n == 15) begin
        set_frame(1);
        bus.load = 1'b1;
      end
    end
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      bus.load = 1'b0;
      chk_sample("b2b_f2", 1, n);
      chk_ovr("b2b_no_ovr", 1'b0);
    end
    @(negedge clk);
    chk_idle("b2b_end", 1'b0);
  endtask

  task automatic test_overrun;
    set_frame(0);
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      bus.load = 1'b0;
      bus.clr_ovr = 1'b0;
      chk_sample("ovr_stream", 0, n);
      if (n == 4) chk_ovr("ovr_set", 1'b1);
      if (n == 6) chk_ovr("ovr_cleared", 1'b0);
      if (n == 9) chk_ovr("ovr_set_wins", 1'b1);
      if (n == 3)  begin set_frame(1); bus.load = 1'b1; end
      if (n == 5)  bus.clr_ovr = 1'b1;
      if (n == 8)  begin bus.load = 1'b1; bus.clr_ovr = 1'b1; end
    end
    @(negedge clk);
    chk_idle("ovr_sticky", 1'b1);
    bus.clr_ovr = 1'b1;
    @(negedge clk);
    bus.clr_ovr = 1'b0;
    chk_idle("ovr_clr", 1'b0);
  endtask

  task automatic test_reset_midframe;
    set_frame(0);
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      bus.load = 1'b0;
      chk_sample("mid_stream", 0, n);
    end
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset_async", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("mid_reset_stays_idle", 1'b0);
    end
    set_frame(1);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk_sample("mid_restart", 1, 0);
    for (int n = 1; n < 16; n++) begin
      @(negedge clk);
      chk_sample("mid_restart", 1, n);
    end
    @(negedge clk);
    chk_idle("mid_restart_end", 1'b0);
  endtask

  initial begin
`ifdef FFT_SER_BITREV_EN
    ord = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
    ord = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
    bus.load = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    bus.out_ready = 1'b0;
    bus.clr_ovr = 1'b0;
    test_reset;
    test_single_frame;
    test_backpressure;
    test_back_to_back;
    test_overrun;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
- Reader side of the FFT output register bank.
- Captures one 16-point complex frame (16 re + 16 im words, already scaled and reordered upstream) in a single cycle on a load strobe.
- Streams the frame out one complex sample per cycle over a valid/ready interface to the downstream sink (UART/DAC/memory writer).
- Frees the parallel FFT outputs immediately after capture, so the next FFT can run while the frame drains.

Parameters:
WORD_SIZE, 16, bit width of each real/imag word (two's complement).
N_POINTS, 16, frame length; fixed at 16 (index width 4). Other values unsupported.

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
load  in  1  one-cycle strobe: the parallel frame on in_re/in_im is valid.
in_re  in  16*WORD_SIZE  real parts; element k at bits [k*WORD_SIZE +: WORD_SIZE].
in_im  in  16*WORD_SIZE  imag parts, same packing.
out_re  out  WORD_SIZE  real part of current streamed sample.
out_im  out  WORD_SIZE  imag part of current streamed sample.
out_idx  out  4  buffer index k of current sample.
out_valid  out  1  sample on out_* is valid.
out_last  out  1  current sample is the final sample of the frame.
out_ready  in  1  sink accepts the sample this cycle.
busy  out  1  frame being streamed (equals out_valid).
overrun  out  1  sticky: a load was dropped.
clr_ovr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; step counter 0.
  - out_valid, out_last, busy and overrun are 0.
  - out_re, out_im and out_idx are 0.
  - Buffer contents are don't-care but are reset to 0.
- FSM states: IDLE and STREAM.
  - IDLE, load=1: all 32 words latch into the internal buffer, step=0, next state STREAM.
  - IDLE, load=0: stay in IDLE; outputs hold 0 and out_valid=0.
  - STREAM: out_valid=1. out_re, out_im and out_idx reflect buf[sel(step)].
  - STREAM, out_valid&&out_ready: step increments.
  - STREAM, handshake with step==15: the frame ends and the next state is IDLE.
  - STREAM, handshake at step 15 together with load=1: the new frame is captured, step=0, and the FSM stays in STREAM. This gives back-to-back frames with no bubble.
  - STREAM, load=1 in any other cycle (no final handshake): the load is ignored, the buffer is unchanged, and overrun is set to 1 on the next edge.
- Output timing: the outputs are a registered mux of the buffer and the next step.
  - load at edge t gives out_valid=1 with sample 0 from edge t+1.
  - Throughput is one sample per cycle while out_ready=1.
  - A frame takes a minimum of 16 cycles.
- Stall: while out_valid=1 and out_ready=0, out_re, out_im, out_idx and out_last hold stable.
- out_last = 1 exactly when out_valid=1 and step==15.
- Data pass through bit-exact; no arithmetic or width change.
- clr_ovr=1 clears overrun on the next edge. If clr_ovr and a dropped load occur in the same cycle, the set wins (overrun=1).
- Reset mid-frame aborts the frame immediately (async). Streaming restarts only on a new load after rst_n deasserts.
- sel(step) = step (natural order) by default.

Optional Feature:
- Macro: FFT_SER_BITREV_EN.
- Defined: sel(step) = bit-reverse of the 4-bit step, so the streaming order is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. out_idx reports the buffer index actually output. out_last still asserts on the 16th handshake, when out_idx=15.
- Not defined: natural order 0..15; out_idx equals step.

Test Plan:
1. Reset then idle: with rst_n low, all outputs are 0. Release rst_n with load=0 for 10 cycles -> out_valid stays 0.
2. Single frame, out_ready=1: in_re[k]=k+1 and in_im[k]=-(k+1) (0xFFFF..0xFFF0), load for 1 cycle.
   - Next cycle: out_valid=1, out_re=1, out_im=0xFFFF, out_idx=0.
   - Sixteen consecutive samples follow; on the 16th, out_re=16, out_im=0xFFF0 and out_last=1.
   - Then out_valid=0 and overrun=0.
3. Backpressure: same frame, out_ready toggling 1,0,0,1,...
   - Outputs hold during the 0 cycles.
   - All 16 samples arrive in order with none duplicated or lost.
   - out_last asserts only on idx 15.
4. Back-to-back frames: assert the second load (in_re[k]=0x100+k) in the cycle of the final handshake of frame 1 -> the next cycle shows out_re=0x100 and out_idx=0 with no out_valid gap.
5. Overrun: load during step 5 -> the stream continues with the old data, overrun=1 and stays 1. Then clr_ovr=1 for 1 cycle -> overrun=0.
6. With FFT_SER_BITREV_EN defined, the test 2 frame -> the out_re sequence is 1,9,5,13,3,11,7,15,2,10,6,14,4,12,8,16. Separately, rst_n pulsed low at step 7 -> out_valid=0 immediately.
